// File: rtl/burst_mem_pkg.sv
// Shared constants and FSM state type for the burst memory responder.
package burst_mem_pkg;

  localparam int BEATS    = 4;
  localparam int BEAT_W   = 64;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT     = 3'd1,
    RD_BURST = 3'd2,
    WR_BURST = 3'd3,
    RECOVER  = 3'd4
  } state_t;

endpackage

// File: rtl/burst_mem_array.sv
// Line-addressed storage kept as beat-wide words so one beat can be
// written per cycle. Read is combinational; write is synchronous.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int LINE_IDX_W = 4
) (
  input  logic                  clk,
  input  logic [LINE_IDX_W-1:0] rd_idx,
  input  logic [1:0]            rd_beat,
  output logic [BEAT_W-1:0]     rd_data,
  input  logic                  we,
  input  logic [LINE_IDX_W-1:0] wr_idx,
  input  logic [1:0]            wr_beat,
  input  logic [BEAT_W-1:0]     wr_data
);

  localparam int DEPTH = (2 ** LINE_IDX_W) * BEATS;

  // Word address is {line index, beat}, so beat k of a line sits at line[64k +: 64].
  logic [BEAT_W-1:0] mem [DEPTH];

  assign rd_data = mem[{rd_idx, rd_beat}];

  // One beat-granular write per edge; contents are untouched by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_idx, wr_beat}] <= wr_data;
    end
  end

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 4-beat x 64-bit burst protocol.
// A request is accepted in IDLE, waits LATENCY edges, then streams four
// beats with resp_o high. RECOVER holds off the next request until the
// initiator has dropped both read_i and write_i for at least one edge.
//
// Handshake: the initiator raises read_i or write_i and holds it until
// the final beat; each edge on which resp_o is high transfers one beat
// (read: burst_o is valid that cycle; write: burst_i is captured at the
// edge ending that cycle). There is no back-pressure once a burst starts.
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int LINE_IDX_W = 4,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o,
  output logic [2:0]  state_dbg
);

  localparam int LAT_W = $clog2(LATENCY + 1);

  state_t                  state;
  logic [LAT_W-1:0]        lat_cnt;
  logic [1:0]              beat;
  logic [LINE_IDX_W-1:0]   line_idx;
  logic                    is_read;

  logic [LINE_IDX_W-1:0]   req_idx;
  logic [1:0]              rd_beat_sel;
  logic [BEAT_W-1:0]       rd_data;
  logic                    mem_we;
  logic                    unused_addr_bits;

  // Offset bits and bits above the index are ignored; upper bits alias.
  assign req_idx          = address_i[LINE_IDX_W+OFFSET_W-1:OFFSET_W];
  assign unused_addr_bits = ^{address_i[31:LINE_IDX_W+OFFSET_W], address_i[OFFSET_W-1:0]};

  assign state_dbg = state;

  // A write beat commits on each edge spent in WR_BURST, except the edge
  // where reset aborts the burst.
  assign mem_we = (state == WR_BURST) && reset_n;

  // burst_o is registered, so the array is read one beat ahead: beat 0
  // while waiting, beat+1 while streaming.
  always_comb begin
    rd_beat_sel = 2'd0;
    if (state == RD_BURST) begin
      rd_beat_sel = beat + 2'd1;
    end
  end

  burst_mem_array #(
    .LINE_IDX_W(LINE_IDX_W)
  ) u_array (
    .clk     (clk),
    .rd_idx  (line_idx),
    .rd_beat (rd_beat_sel),
    .rd_data (rd_data),
    .we      (mem_we),
    .wr_idx  (line_idx),
    .wr_beat (beat),
    .wr_data (burst_i)
  );

  // Transaction FSM with registered beat strobe and read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      resp_o   <= 1'b0;
      burst_o  <= '0;
      lat_cnt  <= '0;
      beat     <= 2'd0;
      line_idx <= '0;
      is_read  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read_i || write_i) begin
            line_idx <= req_idx;
            is_read  <= read_i;
            lat_cnt  <= LAT_W'(LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            beat   <= 2'd0;
            resp_o <= 1'b1;
            if (is_read) begin
              burst_o <= rd_data;
              state   <= RD_BURST;
            end else begin
              state   <= WR_BURST;
            end
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        RD_BURST: begin
          if (beat == 2'd3) begin
            resp_o  <= 1'b0;
            burst_o <= '0;
            beat    <= 2'd0;
            state   <= RECOVER;
          end else begin
            burst_o <= rd_data;
            beat    <= beat + 2'd1;
          end
        end
        WR_BURST: begin
          if (beat == 2'd3) begin
            resp_o <= 1'b0;
            beat   <= 2'd0;
            state  <= RECOVER;
          end else begin
            beat <= beat + 2'd1;
          end
        end
        RECOVER: begin
          if (!read_i && !write_i) begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          resp_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: reset, write/read, latency
// sweep, recovery hold-off, aliasing, read priority and reset mid-write.
module tb_burst_mem_responder;

  localparam int LAT = 3;

  logic        clk;
  logic        reset_n;
  logic [31:0] address_i;
  logic        read_i;
  logic        write_i;
  logic [63:0] burst_i;
  logic [63:0] burst_o;
  logic        resp_o;
  logic [2:0]  state_dbg;

  logic        sw_read;
  logic [63:0] sw1_burst_o, sw7_burst_o;
  logic        sw1_resp_o, sw7_resp_o;
  logic [2:0]  sw1_state, sw7_state;

  int n_checks = 0;
  int n_fail   = 0;

  burst_mem_responder #(.LINE_IDX_W(4), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .burst_i(burst_i), .burst_o(burst_o), .resp_o(resp_o),
    .state_dbg(state_dbg)
  );

  burst_mem_responder #(.LINE_IDX_W(4), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset_n(reset_n), .address_i(32'h0), .read_i(sw_read),
    .write_i(1'b0), .burst_i(64'h0), .burst_o(sw1_burst_o), .resp_o(sw1_resp_o),
    .state_dbg(sw1_state)
  );

  burst_mem_responder #(.LINE_IDX_W(4), .LATENCY(7)) dut_l7 (
    .clk(clk), .reset_n(reset_n), .address_i(32'h0), .read_i(sw_read),
    .write_i(1'b0), .burst_i(64'h0), .burst_o(sw7_burst_o), .resp_o(sw7_resp_o),
    .state_dbg(sw7_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs driven 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full write transaction; line = {beat3, beat2, beat1, beat0}.
  task automatic run_write(input string tag, input logic [31:0] addr, input logic [255:0] line);
    int n;
    int k;
    address_i = addr;
    write_i   = 1'b1;
    burst_i   = line[63:0];
    step();  // acceptance edge
    check({tag, "_acc_resp"}, {63'h0, resp_o}, 64'h0);
    n = 0;
    while (!resp_o && n <= 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(LAT));
    k = 0;
    while (resp_o && k < 8) begin
      check({tag, "_burst_o_zero"}, burst_o, 64'h0);
      step();
      k++;
      if (k < 4) burst_i = line[64*k +: 64];
    end
    check({tag, "_beats"}, 64'(k), 64'd4);
    write_i = 1'b0;
    burst_i = 64'h0;
    step();
  endtask

  // Full read transaction; optionally also raises write_i and holds the
  // request for extra cycles after the last beat.
  task automatic run_read(input string tag, input logic [31:0] addr, input logic [255:0] line,
                          input logic also_write, input int hold);
    int n;
    int k;
    address_i = addr;
    read_i    = 1'b1;
    write_i   = also_write;
    burst_i   = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    check({tag, "_acc_resp"}, {63'h0, resp_o}, 64'h0);
    n = 0;
    while (!resp_o && n <= 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(LAT));
    k = 0;
    while (resp_o && k < 8) begin
      if (k < 4) check({tag, "_data"}, burst_o, line[64*k +: 64]);
      step();
      k++;
    end
    check({tag, "_beats"}, 64'(k), 64'd4);
    check({tag, "_idle_burst_o"}, burst_o, 64'h0);
    for (int h = 0; h < hold; h++) begin
      step();
      check({tag, "_hold_resp"}, {63'h0, resp_o}, 64'h0);
    end
    read_i  = 1'b0;
    write_i = 1'b0;
    burst_i = 64'h0;
    step();
  endtask

  logic [255:0] line_a;
  logic [255:0] line_b;
  logic [255:0] line_c;
  int first1, first7, cnt1, cnt7, n;

  initial begin
    line_a = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    line_b = {64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_F0F0_F0F0,
              64'hCAFE_F00D_1234_5678, 64'h0123_4567_89AB_CDEF};
    line_c = {64'h0, 64'h0, {16{4'hB}}, {16{4'hA}}};

    // Reset held with a read pending
    reset_n   = 1'b0;
    read_i    = 1'b1;
    write_i   = 1'b0;
    address_i = 32'h0;
    burst_i   = 64'h0;
    sw_read   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_resp", {63'h0, resp_o}, 64'h0);
      check("rst_burst_o", burst_o, 64'h0);
      check("rst_state", {61'h0, state_dbg}, 64'h0);
    end

    // Pending read is accepted on the first edge out of reset
    reset_n = 1'b1;
    step();
    check("post_rst_acc", {63'h0, resp_o}, 64'h0);
    n = 0;
    while (!resp_o && n <= 20) begin
      step();
      n++;
    end
    check("post_rst_latency", 64'(n), 64'(LAT));
    n = 0;
    while (resp_o && n < 8) begin
      step();
      n++;
    end
    check("post_rst_beats", 64'(n), 64'd4);
    read_i = 1'b0;
    step();

    // Latency sweep with the request held high throughout
    sw_read = 1'b1;
    step();
    first1 = 0; first7 = 0; cnt1 = 0; cnt7 = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (sw1_resp_o) begin
        if (first1 == 0) first1 = c;
        cnt1++;
      end
      if (sw7_resp_o) begin
        if (first7 == 0) first7 = c;
        cnt7++;
      end
    end
    check("lat1_first", 64'(first1), 64'd1);
    check("lat7_first", 64'(first7), 64'd7);
    check("lat1_count", 64'(cnt1), 64'd4);
    check("lat7_count", 64'(cnt7), 64'd4);
    sw_read = 1'b0;
    step();

    // Write then read with a non-zero offset
    run_write("wr40", 32'h0000_0040, line_a);
    run_read("rd5c", 32'h0000_005C, line_a, 1'b0, 0);

    // Recovery: request held 3 cycles after the last beat
    run_read("recov", 32'h0000_0040, line_a, 1'b0, 3);
    run_read("after_recov", 32'h0000_0040, line_a, 1'b0, 0);

    // Aliasing: 0x200 wraps onto line 0
    run_write("wr200", 32'h0000_0200, line_b);
    run_read("rd000", 32'h0000_0000, line_b, 1'b0, 0);

    // Read wins over write, storage unchanged
    run_read("rdwr_both", 32'h0000_0000, line_b, 1'b1, 0);
    run_read("rd000_again", 32'h0000_0000, line_b, 1'b0, 0);

    // Reset mid-write to a zeroed line
    run_write("zero_a0", 32'h0000_00A0, 256'h0);
    address_i = 32'h0000_00A0;
    write_i   = 1'b1;
    burst_i   = {16{4'hA}};
    step();
    n = 0;
    while (!resp_o && n <= 20) begin
      step();
      n++;
    end
    check("midrst_latency", 64'(n), 64'(LAT));
    step();  // beat 0 committed
    burst_i = {16{4'hB}};
    step();  // beat 1 committed
    burst_i = {16{4'hC}};
    reset_n = 1'b0;
    step();
    check("midrst_resp", {63'h0, resp_o}, 64'h0);
    check("midrst_burst_o", burst_o, 64'h0);
    reset_n = 1'b1;
    write_i = 1'b0;
    burst_i = 64'h0;
    step();
    run_read("rd_a0", 32'h0000_00A0, line_c, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
- Memory-side responder for the 4-beat x 64-bit burst protocol driven by the LLC cacheline adaptor; serves 256-bit lines as bursts.
- Backs requests with an internal line-addressed storage array and a programmable first-beat latency.
- Used as the main-memory model in cache/adaptor testbenches and as the on-chip burst target in integration.

Parameters:
- LINE_IDX_W, 4, index bits of storage; array holds 2**LINE_IDX_W 256-bit lines.
- LATENCY, 3, cycles from request acceptance to first resp_o beat; legal range >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  reset; synchronous, active-low.
- address_i  input  32  byte address; bits [4:0] ignored; line index = address_i[LINE_IDX_W+4:5]; upper bits ignored (aliasing wrap).
- read_i  input  1  read request; initiator holds it high until final beat.
- write_i  input  1  write request; initiator holds it high until final beat.
- burst_i  input  64  write beat data from initiator.
- burst_o  output  64  read beat data; registered.
- resp_o  output  1  beat strobe; high exactly 4 consecutive cycles per transaction.

Behaviour:
- Reset (reset_n low at an edge): state IDLE, resp_o=0, burst_o=0, counters 0. Storage contents are not modified by reset; simulation initial contents all zero.
- States: IDLE, WAIT, RD_BURST, WR_BURST, RECOVER.
- IDLE: on an edge with read_i or write_i high, latch line index and direction (read wins if both high), load latency counter with LATENCY-1, go to WAIT.
- WAIT: decrement each edge; when counter is 0 at an edge, go to RD_BURST/WR_BURST with beat=0 and resp_o=1. The first resp_o-high cycle follows acceptance edge E0 by exactly LATENCY edges (resp_o high after edge E0+LATENCY).
- RD_BURST: in the cycle beat k is presented, burst_o = line[64k +: 64] and resp_o=1; beat increments each edge; after beat 3 go to RECOVER with resp_o=0, burst_o=0.
- WR_BURST: at the edge ending the k-th resp_o-high cycle (k=0..3), burst_i is written to line[64k +: 64]. The initiator holds beat 0 from request until the first such edge and advances one beat per resp_o-high edge. After beat 3 go to RECOVER. Each beat commits immediately.
- RECOVER: resp_o=0; stay until read_i and write_i are both low at an edge, then IDLE. Back-to-back transactions therefore need at least one idle-request cycle.
- burst_o is 0 whenever resp_o is 0.
- address_i, read_i and write_i changes after acceptance are ignored until RECOVER.
- A request deasserted early (during WAIT or a burst) does not abort; the burst completes.
- Reset mid-burst: abort at that edge; outputs as reset; write beats already committed remain in storage, beats not yet captured are lost.
- Beat counter is 2 bits and wraps only via the state exit; the latency counter is $clog2(LATENCY+1) bits.

Decomposition:
- Package burst_mem_pkg: BEATS=4, BEAT_W=64, LINE_W=256, OFFSET_W=5, state enum (IDLE, WAIT, RD_BURST, WR_BURST, RECOVER).
- Sub-module burst_mem_array holds the storage:
  - read port: combinational, by line index and beat;
  - write port: one beat-granular synchronous write (index, beat, data, we).
- The top level contains only the FSM, the latched index and the counters.

Test Plan:
- Reset: hold reset_n=0 for 2 edges with read_i=1 -> resp_o=0, burst_o=0 throughout; no transaction starts until the first edge with reset_n=1.
- Write then read: write line at 0x0000_0040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> resp_o high 4 cycles starting 3 edges after acceptance. A following read of 0x0000_005C (offset ignored) returns the same 4 beats in order.
- Latency sweep: LATENCY=1 and LATENCY=7 -> first resp_o exactly 1 and 7 edges after acceptance; resp_o always exactly 4 cycles.
- Recovery: initiator holds read_i high after the last beat -> no new resp_o until read_i drops for at least one edge; then a new read is accepted.
- Aliasing: LINE_IDX_W=4; write 0x0000_0200, read 0x0000_0000 -> identical data. With read_i and write_i both high, a read is performed and storage is unchanged.
- Reset mid-write: pulse reset_n low after beat 1 edge of a write of 0xAA.., 0xBB.. to a zeroed line -> subsequent read returns 0xAA.., 0xBB.., 0, 0.
